cam_lvds_pattern_tx: RTL and testbench

//  Camera-side emulator of the 5-channel x8 LVDS camera link: 4 data lanes + 1 sync lane.

---
 rtl/cam_lvds_pattern_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_cam_lvds_pattern_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_lvds_pattern_tx.sv
// cam_lvds_pattern_tx: test-pattern source for the 5-channel x8 camera LVDS link.
// Emits one 40-bit word per enabled cycle, txd[8n+7:8n] = channel n, channel 4 = sync,
// in the same layout the camera deserializer presents.
// Optional feature: define CAM_TX_CRC_EN to insert a per-line CRC-8 word after each EOL.
// Ports:
//   c          word clock
//   rst        synchronous reset, active-high
//   ce         word enable; low holds all state and outputs
//   start      begin a frame (accepted only in IDLE with ce=1)
//   cont       restart after the frame end without a new start
//   mode       0/3 ramp, 1 constant, 2 frame-count fill
//   const_val  pixel value for mode 1
//   cols/rows  IMG words per line / lines per frame (0 is taken as 1)
//   hblank     BL cycles after each line, vblank BL cycles after the last line
//   txd        {sync, lane3, lane2, lane1, lane0}
//   busy       high from start acceptance to the last frame cycle
//   frame_done one-cycle pulse on the last frame cycle
//   frame_cnt  completed frames, wraps at 2^16
module cam_lvds_pattern_tx #(
  parameter int unsigned CW    = 12,
  parameter int unsigned RW    = 12,
  parameter int unsigned BW    = 16,
  parameter logic [7:0]  TRAIN = 8'h3A
) (
  input  logic          c,
  input  logic          rst,
  input  logic          ce,
  input  logic          start,
  input  logic          cont,
  input  logic [1:0]    mode,
  input  logic [7:0]    const_val,
  input  logic [CW-1:0] cols,
  input  logic [RW-1:0] rows,
  input  logic [BW-1:0] hblank,
  input  logic [BW-1:0] vblank,
  output logic [39:0]   txd,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned FCW = 16;
  localparam logic [7:0] SC_FS  = 8'hAA;
  localparam logic [7:0] SC_LS  = 8'h2A;
  localparam logic [7:0] SC_IMG = 8'h35;
  localparam logic [7:0] SC_LE  = 8'h12;
  localparam logic [7:0] SC_FE  = 8'h4A;
  localparam logic [7:0] SC_BL  = 8'h15;
  localparam logic [31:0] TRAIN4 = {4{TRAIN}};

`ifdef CAM_TX_CRC_EN
  localparam logic [7:0] SC_CRC = 8'h55;
  typedef enum logic [2:0] {S_IDLE, S_SOL, S_IMG, S_EOL, S_CRC, S_HBL, S_VBL} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SOL, S_IMG, S_EOL, S_HBL, S_VBL} state_t;
`endif

  // state is the cycle currently shown on txd; every register loads its next value on ce
  state_t        state, nxt_state;
  logic [RW-1:0] row, nxt_row, rows_l;
  logic [CW-1:0] col, nxt_col, cols_l;
  logic [BW-1:0] bcnt, nxt_bcnt, hblank_l, vblank_l;
  logic [1:0]    mode_l;
  logic [7:0]    const_l;
  logic [39:0]   nxt_txd;
  logic [31:0]   nxt_pix;
  logic          nxt_busy, nxt_fd, latch, last_row;
  logic          line_end, blank_end, frame_end;
`ifdef CAM_TX_CRC_EN
  logic [31:0]   crc_q, nxt_crc;
`endif

  // Pixel word for line r, word column w
  function automatic logic [31:0] pix_word(input logic [1:0] m, input logic [RW-1:0] r,
                                           input logic [CW-1:0] w, input logic [7:0] cv,
                                           input logic [7:0] fc);
    logic [31:0] p;
    p = '0;
    for (int k = 0; k < 4; k++) begin
      case (m)
        2'd1:    p[8*k +: 8] = cv;
        2'd2:    p[8*k +: 8] = fc;
        default: p[8*k +: 8] = 8'(8'(w) * 8'd4 + 8'(k) + 8'(r));
      endcase
    end
    return p;
  endfunction

`ifdef CAM_TX_CRC_EN
  // CRC-8, poly 0x07, MSB-first, one byte
  function automatic logic [7:0] crc8(input logic [7:0] cin, input logic [7:0] d);
    logic [7:0] x;
    x = cin ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction
`endif

  assign last_row = (row == rows_l - RW'(1));

  // Next state, counters and next output word
  always_comb begin
    nxt_state = state;
    nxt_row   = row;
    nxt_col   = col;
    nxt_bcnt  = bcnt;
    nxt_busy  = busy;
    latch     = 1'b0;
    line_end  = 1'b0;
    blank_end = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        latch     = 1'b1;
        nxt_state = S_SOL;
        nxt_row   = '0;
        nxt_busy  = 1'b1;
      end
      S_SOL: begin
        nxt_state = S_IMG;
        nxt_col   = '0;
      end
      S_IMG: if (col == cols_l - CW'(1)) nxt_state = S_EOL;
             else nxt_col = col + CW'(1);
`ifdef CAM_TX_CRC_EN
      S_EOL: nxt_state = S_CRC;
      S_CRC: line_end = 1'b1;
`else
      S_EOL: line_end = 1'b1;
`endif
      S_HBL: if (bcnt == hblank_l) blank_end = 1'b1;
             else nxt_bcnt = bcnt + BW'(1);
      S_VBL: if (bcnt == vblank_l) frame_end = 1'b1;
             else nxt_bcnt = bcnt + BW'(1);
      default: nxt_state = S_IDLE;
    endcase
    // zero-length blanking periods fall straight through to the following step
    if (line_end) begin
      if (hblank_l != '0) begin
        nxt_state = S_HBL;
        nxt_bcnt  = BW'(1);
      end else blank_end = 1'b1;
    end
    if (blank_end) begin
      if (!last_row) begin
        nxt_state = S_SOL;
        nxt_row   = row + RW'(1);
      end else if (vblank_l != '0) begin
        nxt_state = S_VBL;
        nxt_bcnt  = BW'(1);
      end else frame_end = 1'b1;
    end
    if (frame_end) begin
      if (cont) begin
        latch     = 1'b1;
        nxt_state = S_SOL;
        nxt_row   = '0;
      end else begin
        nxt_state = S_IDLE;
        nxt_busy  = 1'b0;
      end
    end

    nxt_pix = pix_word(mode_l, row, nxt_col, const_l, frame_cnt[7:0]);
    nxt_fd  = 1'b0;
    nxt_txd = {SC_BL, TRAIN4};
    // frame_done marks the cycle being entered when it is the frame's last one
    case (nxt_state)
      S_SOL: nxt_txd = {(nxt_row == '0) ? SC_FS : SC_LS, TRAIN4};
      S_IMG: nxt_txd = {SC_IMG, nxt_pix};
      S_EOL: begin
        nxt_txd = {last_row ? SC_FE : SC_LE, TRAIN4};
`ifndef CAM_TX_CRC_EN
        nxt_fd  = last_row && (hblank_l == '0) && (vblank_l == '0);
`endif
      end
`ifdef CAM_TX_CRC_EN
      S_CRC: begin
        nxt_txd = {SC_CRC, crc_q};
        nxt_fd  = last_row && (hblank_l == '0) && (vblank_l == '0);
      end
`endif
      S_HBL: nxt_fd = last_row && (vblank_l == '0) && (nxt_bcnt == hblank_l);
      S_VBL: nxt_fd = (nxt_bcnt == vblank_l);
      default: ;
    endcase

`ifdef CAM_TX_CRC_EN
    // per-lane CRC over the IMG bytes of the current line
    nxt_crc = crc_q;
    if (nxt_state == S_SOL) nxt_crc = '0;
    else if (nxt_state == S_IMG)
      for (int k = 0; k < 4; k++) nxt_crc[8*k +: 8] = crc8(crc_q[8*k +: 8], nxt_pix[8*k +: 8]);
`endif
  end

  // State, configuration and output registers
  always_ff @(posedge c) begin
    if (rst) begin
      state      <= S_IDLE;
      row        <= '0;
      col        <= '0;
      bcnt       <= '0;
      rows_l     <= RW'(1);
      cols_l     <= CW'(1);
      hblank_l   <= '0;
      vblank_l   <= '0;
      mode_l     <= '0;
      const_l    <= '0;
      txd        <= {SC_BL, TRAIN4};
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
`ifdef CAM_TX_CRC_EN
      crc_q      <= '0;
`endif
    end else if (ce) begin
      state      <= nxt_state;
      row        <= nxt_row;
      col        <= nxt_col;
      bcnt       <= nxt_bcnt;
      txd        <= nxt_txd;
      busy       <= nxt_busy;
      frame_done <= nxt_fd;
      frame_cnt  <= frame_cnt + FCW'(nxt_fd);
`ifdef CAM_TX_CRC_EN
      crc_q      <= nxt_crc;
`endif
      if (latch) begin
        cols_l   <= (cols == '0) ? CW'(1) : cols;
        rows_l   <= (rows == '0) ? RW'(1) : rows;
        hblank_l <= hblank;
        vblank_l <= vblank;
        mode_l   <= mode;
        const_l  <= const_val;
      end
    end
  end

endmodule

// File: tb/tb_cam_lvds_pattern_tx.sv
// Self-checking bench for cam_lvds_pattern_tx: a frame-level reference model builds the
// expected per-cycle word stream, which each scenario task compares against the DUT.
module tb_cam_lvds_pattern_tx;

  localparam int unsigned CW = 12;
  localparam int unsigned RW = 12;
  localparam int unsigned BW = 16;
  localparam logic [7:0]  TR = 8'h3A;
  localparam logic [39:0] IDLE_W = 40'h15_3A3A3A3A;

  typedef struct packed {
    logic [39:0] w;
    logic        fd;
  } ev_t;

  logic          c = 1'b0;
  logic          rst, ce, start, cont;
  logic [1:0]    mode;
  logic [7:0]    const_val;
  logic [CW-1:0] cols;
  logic [RW-1:0] rows;
  logic [BW-1:0] hblank, vblank;
  logic [39:0]   txd;
  logic          busy, frame_done;
  logic [15:0]   frame_cnt;

  int  checks = 0;
  int  errors = 0;
  int  mcnt = 0;
  ev_t exp_q[$];

  cam_lvds_pattern_tx #(.CW(CW), .RW(RW), .BW(BW), .TRAIN(TR)) dut (
    .c(c), .rst(rst), .ce(ce), .start(start), .cont(cont), .mode(mode),
    .const_val(const_val), .cols(cols), .rows(rows), .hblank(hblank), .vblank(vblank),
    .txd(txd), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 c = ~c;

  function automatic logic [7:0] m_crc(input logic [7:0] cr, input logic [7:0] d);
    logic [7:0] x;
    x = cr ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  // Reference model: append one whole frame (as the spec describes it) to exp_q
  task automatic add_frame(input int nc, input int nr, input int hb, input int vb,
                           input int md, input int cv);
    int ec, er;
    ev_t e;
    logic [7:0] crc [4];
    logic [31:0] px;
    ec = (nc == 0) ? 1 : nc;
    er = (nr == 0) ? 1 : nr;
    for (int r = 0; r < er; r++) begin
      e.fd = 1'b0;
      e.w = {(r == 0) ? 8'hAA : 8'h2A, {4{TR}}}; exp_q.push_back(e);
      for (int k = 0; k < 4; k++) crc[k] = 8'h00;
      for (int w = 0; w < ec; w++) begin
        for (int k = 0; k < 4; k++) begin
          if (md == 1)      px[8*k +: 8] = 8'(cv);
          else if (md == 2) px[8*k +: 8] = 8'(mcnt % 256);
          else              px[8*k +: 8] = 8'((4*w + k + r) % 256);
          crc[k] = m_crc(crc[k], px[8*k +: 8]);
        end
        e.w = {8'h35, px}; exp_q.push_back(e);
      end
      e.w = {(r == er-1) ? 8'h4A : 8'h12, {4{TR}}}; exp_q.push_back(e);
`ifdef CAM_TX_CRC_EN
      e.w = {8'h55, crc[3], crc[2], crc[1], crc[0]}; exp_q.push_back(e);
`endif
      for (int i = 0; i < hb; i++) begin e.w = IDLE_W; exp_q.push_back(e); end
    end
    for (int i = 0; i < vb; i++) begin e.w = IDLE_W; exp_q.push_back(e); end
    e = exp_q.pop_back();
    e.fd = 1'b1;
    exp_q.push_back(e);
    mcnt++;
  endtask

  task automatic set_cfg(input int nc, input int nr, input int hb, input int vb,
                         input int md, input int cv);
    cols = CW'(nc); rows = RW'(nr); hblank = BW'(hb); vblank = BW'(vb);
    mode = 2'(md); const_val = 8'(cv);
  endtask

  task automatic test_reset;
    rst = 1'b1; ce = 1'b1; start = 1'b0; cont = 1'b0;
    set_cfg(2, 2, 1, 2, 0, 0);
    @(negedge c);
    rst = 1'b0;
    checks++; if (txd !== IDLE_W) begin errors++; $display("FAIL reset_txd got %h exp %h", txd, IDLE_W); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", frame_cnt); end
    mcnt = 0;
    @(negedge c);
    checks++; if (txd !== IDLE_W || busy !== 1'b0) begin errors++; $display("FAIL idle_hold got %h/%b exp %h/0", txd, busy, IDLE_W); end
  endtask

  task automatic test_frame_fixed;
    logic [7:0] sync_ref [12] = '{8'hAA, 8'h35, 8'h35, 8'h12, 8'h15, 8'h2A,
                                  8'h35, 8'h35, 8'h4A, 8'h15, 8'h15, 8'h15};
    logic [31:0] img_ref [4] = '{32'h03020100, 32'h07060504, 32'h04030201, 32'h08070605};
    int img_i;
    exp_q.delete();
    set_cfg(2, 2, 1, 2, 0, 0);
    add_frame(2, 2, 1, 2, 0, 0);
    @(negedge c); start = 1'b1;
    @(negedge c); start = 1'b0;
    img_i = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ({txd, busy, frame_done} !== {exp_q[i].w, 1'b1, exp_q[i].fd}) begin
        errors++;
        $display("FAIL frame_fixed cyc %0d got txd=%h busy=%b fd=%b exp txd=%h busy=1 fd=%b",
                 i, txd, busy, frame_done, exp_q[i].w, exp_q[i].fd);
      end
`ifndef CAM_TX_CRC_EN
      checks++; if (txd[39:32] !== sync_ref[i]) begin errors++; $display("FAIL sync_seq cyc %0d got %h exp %h", i, txd[39:32], sync_ref[i]); end
`endif
      if (txd[39:32] == 8'h35 && img_i < 4) begin
        checks++; if (txd[31:0] !== img_ref[img_i]) begin errors++; $display("FAIL img_lanes %0d got %h exp %h", img_i, txd[31:0], img_ref[img_i]); end
        img_i++;
      end
      @(negedge c);
    end
    checks++; if ({txd, busy, frame_done} !== {IDLE_W, 2'b00}) begin errors++; $display("FAIL frame_fixed_end got %h/%b/%b exp %h/0/0", txd, busy, frame_done, IDLE_W); end
    checks++; if (frame_cnt !== 16'(mcnt)) begin errors++; $display("FAIL frame_fixed_cnt got %0d exp %0d", frame_cnt, mcnt); end
  endtask

  task automatic test_cont_mode2;
    int flen;
    exp_q.delete();
    set_cfg(1, 1, 0, 0, 2, 0);
    for (int f = 0; f < 4; f++) add_frame(1, 1, 0, 0, 2, 0);
    flen = exp_q.size() / 4;
    cont = 1'b1;
    @(negedge c); start = 1'b1;
    @(negedge c); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == exp_q.size() - flen) cont = 1'b0;
      checks++;
      if ({txd, busy, frame_done} !== {exp_q[i].w, 1'b1, exp_q[i].fd}) begin
        errors++;
        $display("FAIL cont_mode2 cyc %0d got txd=%h busy=%b fd=%b exp txd=%h busy=1 fd=%b",
                 i, txd, busy, frame_done, exp_q[i].w, exp_q[i].fd);
      end
      @(negedge c);
    end
    checks++; if ({txd, busy} !== {IDLE_W, 1'b0}) begin errors++; $display("FAIL cont_end got %h/%b exp %h/0", txd, busy, IDLE_W); end
    checks++; if (frame_cnt !== 16'(mcnt)) begin errors++; $display("FAIL cont_cnt got %0d exp %0d", frame_cnt, mcnt); end
  endtask

  // Random configs; start and config inputs are disturbed mid-frame and must be ignored
  task automatic test_random_frames;
    int nc, nr, hb, vb, md, cv, j;
    for (int f = 0; f < 8; f++) begin
      nc = $urandom_range(0, 5); nr = $urandom_range(0, 3);
      hb = $urandom_range(0, 3); vb = $urandom_range(0, 3);
      md = $urandom_range(0, 3); cv = $urandom_range(0, 255);
      exp_q.delete();
      set_cfg(nc, nr, hb, vb, md, cv);
      add_frame(nc, nr, hb, vb, md, cv);
      j = $urandom_range(0, exp_q.size() - 1);
      @(negedge c); start = 1'b1;
      @(negedge c); start = 1'b0;
      set_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
              $urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 255));
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if ({txd, busy, frame_done} !== {exp_q[i].w, 1'b1, exp_q[i].fd}) begin
          errors++;
          $display("FAIL random f%0d cyc %0d got txd=%h busy=%b fd=%b exp txd=%h busy=1 fd=%b",
                   f, i, txd, busy, frame_done, exp_q[i].w, exp_q[i].fd);
        end
        start = (i == j);
        @(negedge c);
      end
      start = 1'b0;
      checks++; if ({txd, busy, frame_done} !== {IDLE_W, 2'b00}) begin errors++; $display("FAIL random_end f%0d got %h/%b/%b exp %h/0/0", f, txd, busy, frame_done, IDLE_W); end
      checks++; if (frame_cnt !== 16'(mcnt)) begin errors++; $display("FAIL random_cnt f%0d got %0d exp %0d", f, frame_cnt, mcnt); end
    end
  endtask

  task automatic test_reset_mid;
    int row1_img;
    exp_q.delete();
    set_cfg(2, 2, 1, 2, 0, 0);
    add_frame(2, 2, 1, 2, 0, 0);
    row1_img = 0;
    for (int i = 1; i < exp_q.size(); i++)
      if (exp_q[i].w[39:32] == 8'h2A) begin row1_img = i + 1; break; end
    @(negedge c); start = 1'b1;
    @(negedge c); start = 1'b0;
    for (int i = 0; i < row1_img; i++) @(negedge c);
    checks++; if (txd[39:32] !== 8'h35) begin errors++; $display("FAIL rst_mid_pos got %h exp 35", txd[39:32]); end
    rst = 1'b1;
    @(negedge c);
    rst = 1'b0;
    mcnt = 0;
    checks++; if ({txd, busy, frame_done} !== {IDLE_W, 2'b00}) begin errors++; $display("FAIL rst_mid got %h/%b/%b exp %h/0/0", txd, busy, frame_done, IDLE_W); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", frame_cnt); end
    for (int i = 0; i < 6; i++) begin
      @(negedge c);
      checks++; if ({txd, busy, frame_done} !== {IDLE_W, 2'b00}) begin errors++; $display("FAIL rst_mid_idle %0d got %h/%b/%b", i, txd, busy, frame_done); end
    end
  endtask

  task automatic test_ce_toggle;
    exp_q.delete();
    set_cfg(2, 2, 1, 2, 0, 0);
    add_frame(2, 2, 1, 2, 0, 0);
    @(negedge c); start = 1'b1; ce = 1'b1;
    @(negedge c); start = 1'b0; ce = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int h = 0; h < 2; h++) begin
        checks++;
        if ({txd, busy, frame_done} !== {exp_q[i].w, 1'b1, exp_q[i].fd}) begin
          errors++;
          $display("FAIL ce_toggle cyc %0d.%0d got txd=%h busy=%b fd=%b exp txd=%h busy=1 fd=%b",
                   i, h, txd, busy, frame_done, exp_q[i].w, exp_q[i].fd);
        end
        @(negedge c);
        ce = (h == 0);
      end
    end
    ce = 1'b1;
    checks++; if ({txd, busy, frame_done} !== {IDLE_W, 2'b00}) begin errors++; $display("FAIL ce_end got %h/%b/%b exp %h/0/0", txd, busy, frame_done, IDLE_W); end
    checks++; if (frame_cnt !== 16'(mcnt)) begin errors++; $display("FAIL ce_cnt got %0d exp %0d", frame_cnt, mcnt); end
  endtask

`ifdef CAM_TX_CRC_EN
  task automatic test_crc;
    exp_q.delete();
    set_cfg(1, 2, 0, 1, 1, 1);
    add_frame(1, 2, 0, 1, 1, 1);
    @(negedge c); start = 1'b1;
    @(negedge c); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ({txd, busy, frame_done} !== {exp_q[i].w, 1'b1, exp_q[i].fd}) begin
        errors++;
        $display("FAIL crc cyc %0d got txd=%h busy=%b fd=%b exp txd=%h fd=%b",
                 i, txd, busy, frame_done, exp_q[i].w, exp_q[i].fd);
      end
      if (i == 3) begin
        checks++; if (txd !== 40'h55_07070707) begin errors++; $display("FAIL crc_word got %h exp 5507070707", txd); end
      end
      start = (i == 2);
      @(negedge c);
    end
    start = 1'b0;
    checks++; if (frame_cnt !== 16'(mcnt)) begin errors++; $display("FAIL crc_cnt got %0d exp %0d", frame_cnt, mcnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_fixed();
    test_cont_mode2();
    test_random_frames();
`ifdef CAM_TX_CRC_EN
    test_crc();
`endif
    test_reset_mid();
    test_ce_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
